// File: rtl/mdu_if.sv
// Execute-stage <-> multiply/divide unit bundle: operation request, HI/LO read-back and hazard status.
// The master side is the pipeline; the slave side is the mdu_seq sequencer.
interface mdu_if #(
  parameter int WIDTH = 32
);
  logic             md_start;
  logic [2:0]       md_op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             read_req;
  logic             flush;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  logic             busy_o;
  logic             done_o;
  logic             stall_o;

  modport master (
    output md_start, md_op, rs_val, rt_val, read_req, flush,
    input  hi_o, lo_o, busy_o, done_o, stall_o
  );

  modport slave (
    input  md_start, md_op, rs_val, rt_val, read_req, flush,
    output hi_o, lo_o, busy_o, done_o, stall_o
  );
endinterface

// File: rtl/mdu_seq.sv
// Iterative MIPS multiply/divide sequencer owning HI/LO: radix-2 shift-add and restoring divide over WIDTH cycles.
// Define MDU_MADD_EN to enable madd/maddu (ops 6/7) accumulating into {HI,LO}; otherwise those ops are ignored.
module mdu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic  clk,
  input logic  rst_n,
  mdu_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_e;
  typedef enum logic [1:0] {K_MUL = 2'd0, K_DIV = 2'd1, K_MAC = 2'd2} kind_e;

  state_e           state_q, state_d;
  kind_e            kind_q, kind_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;   // product high half / partial remainder
  logic [WIDTH-1:0] q_q, q_d;       // multiplier, then product low half / dividend, then quotient
  logic [WIDTH-1:0] b_q, b_d;       // multiplicand / divisor magnitude
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             neg_res_q, neg_res_d, neg_rem_q, neg_rem_d, div0_q, div0_d;

  logic             op_mul, op_div, op_mac, op_mthi, op_mtlo, op_signed;
  logic             rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_abs, rt_abs;

  assign op_mul    = (bus.md_op[2:1] == 2'b00);
  assign op_div    = (bus.md_op[2:1] == 2'b01);
  assign op_mthi   = (bus.md_op == 3'd4);
  assign op_mtlo   = (bus.md_op == 3'd5);
`ifdef MDU_MADD_EN
  assign op_mac    = (bus.md_op[2:1] == 2'b11);
`else
  assign op_mac    = 1'b0;
`endif
  // Even opcodes (mult, div, madd) are the signed variants.
  assign op_signed = ~bus.md_op[0];
  assign rs_neg    = op_signed & bus.rs_val[WIDTH-1];
  assign rt_neg    = op_signed & bus.rt_val[WIDTH-1];
  assign rs_abs    = rs_neg ? -bus.rs_val : bus.rs_val;
  assign rt_abs    = rt_neg ? -bus.rt_val : bus.rt_val;

  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] prod_mag, prod;

  assign mul_sum   = {1'b0, acc_q} + (q_q[0] ? {1'b0, b_q} : '0);
  assign div_shift = {acc_q, q_q[WIDTH-1]};
  // Partial remainder stays below the divisor, so bit WIDTH of the difference is a reliable borrow.
  assign div_diff  = div_shift - {1'b0, b_q};
  assign prod_mag  = {acc_q, q_q};
  assign prod      = neg_res_q ? -prod_mag : prod_mag;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d   = state_q;
    kind_d    = kind_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    q_d       = q_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;

    case (state_q)
      IDLE: begin
        if (bus.md_start && !bus.flush) begin
          if (op_mthi) begin
            hi_d = bus.rs_val;
          end else if (op_mtlo) begin
            lo_d = bus.rs_val;
          end else if (op_mul || op_div || op_mac) begin
            kind_d    = op_div ? K_DIV : (op_mac ? K_MAC : K_MUL);
            acc_d     = '0;
            b_d       = op_div ? rt_abs : rs_abs;
            q_d       = op_div ? rs_abs : rt_abs;
            neg_res_d = rs_neg ^ rt_neg;
            neg_rem_d = rs_neg;
            div0_d    = op_div && (bus.rt_val == '0);
            cnt_d     = CNT_W'(WIDTH - 1);
            state_d   = RUN;
          end
        end
      end
      RUN: begin
        if (bus.flush) begin
          state_d = IDLE;
        end else begin
          if (kind_q == K_DIV) begin
            if (!div_diff[WIDTH]) begin
              acc_d = div_diff[WIDTH-1:0];
              q_d   = {q_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_d = div_shift[WIDTH-1:0];
              q_d   = {q_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_d = mul_sum[WIDTH:1];
            q_d   = {mul_sum[0], q_q[WIDTH-1:1]};
          end
          if (cnt_q == '0) state_d = FIX;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!bus.flush) begin
          case (kind_q)
            K_DIV: begin
              // Divide-by-zero: quotient all ones; the unsigned remainder re-signed is rs_val itself.
              lo_d = div0_q ? '1 : (neg_res_q ? -q_q : q_q);
              hi_d = neg_rem_q ? -acc_q : acc_q;
            end
`ifdef MDU_MADD_EN
            K_MAC:   {hi_d, lo_d} = {hi_q, lo_q} + prod;
`endif
            default: {hi_d, lo_d} = prod;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      kind_q    <= K_MUL;
      cnt_q     <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of the others.
      state_q   <= state_d;
      kind_q    <= kind_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      b_q       <= b_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
    end
  end

  assign bus.hi_o    = hi_q;
  assign bus.lo_o    = lo_q;
  assign bus.busy_o  = (state_q != IDLE);
  assign bus.done_o  = (state_q == FIX) && !bus.flush;
  assign bus.stall_o = bus.busy_o & (bus.read_req | bus.md_start);
endmodule

// File: tb/tb_mdu_seq.sv
// Directed self-checking bench for mdu_seq: products, quotients, stall/flush/reset behaviour and madd.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mdu_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mdu_if #(.WIDTH(32)) bus ();

  mdu_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Presents one op for a single cycle, scrambles the operand buses, then counts busy cycles and done pulses.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cyc, output int done_cnt);
    @(negedge clk);
    bus.md_start = 1'b1; bus.md_op = op; bus.rs_val = a; bus.rt_val = b;
    @(negedge clk);
    bus.md_start = 1'b0; bus.rs_val = 32'hDEADBEEF; bus.rt_val = 32'h0BADF00D;
    busy_cyc = 0; done_cnt = 0;
    while (bus.busy_o === 1'b1 && busy_cyc < 100) begin
      busy_cyc++;
      if (bus.done_o === 1'b1) done_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic write_hilo(input logic [2:0] op, input logic [31:0] val, input logic fl);
    @(negedge clk);
    bus.md_start = 1'b1; bus.md_op = op; bus.rs_val = val; bus.flush = fl;
    @(negedge clk);
    bus.md_start = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (bus.hi_o !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want %h", bus.hi_o, 32'h0); end
    checks++; if (bus.lo_o !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want %h", bus.lo_o, 32'h0); end
    checks++; if ({bus.busy_o, bus.done_o, bus.stall_o} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b want 000", {bus.busy_o, bus.done_o, bus.stall_o});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_multu_max();
    int bc, dc;
    run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, bc, dc);
    checks++; if (bc !== 33) begin errors++; $display("FAIL multu_busy_cycles got %0d want 33", bc); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL multu_done_pulses got %0d want 1", dc); end
    checks++; if (bus.hi_o !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi got %h want fffffffe", bus.hi_o); end
    checks++; if (bus.lo_o !== 32'h00000001) begin errors++; $display("FAIL multu_lo got %h want 00000001", bus.lo_o); end
  endtask

  task automatic test_mult();
    logic [2:0]  op [3] = '{3'd0, 3'd0, 3'd1};
    logic [31:0] a  [3] = '{32'hFFFFFFFD, 32'h80000000, 32'h00012345};
    logic [31:0] b  [3] = '{32'h00000005, 32'h80000000, 32'h00010000};
    logic [31:0] eh [3] = '{32'hFFFFFFFF, 32'h40000000, 32'h00000001};
    logic [31:0] el [3] = '{32'hFFFFFFF1, 32'h00000000, 32'h23450000};
    int bc, dc;
    for (int i = 0; i < 3; i++) begin
      run_op(op[i], a[i], b[i], bc, dc);
      checks++; if (bus.hi_o !== eh[i]) begin errors++; $display("FAIL mult%0d_hi got %h want %h", i, bus.hi_o, eh[i]); end
      checks++; if (bus.lo_o !== el[i]) begin errors++; $display("FAIL mult%0d_lo got %h want %h", i, bus.lo_o, el[i]); end
    end
  endtask

  task automatic test_div();
    logic [2:0]  op [6] = '{3'd2, 3'd3, 3'd3, 3'd2, 3'd2, 3'd2};
    logic [31:0] a  [6] = '{32'hFFFFFFF9, 32'd100, 32'd5, 32'h80000000, 32'd7, 32'hFFFFFFF9};
    logic [31:0] b  [6] = '{32'd2, 32'd7, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd0};
    logic [31:0] el [6] = '{32'hFFFFFFFD, 32'd14, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFD, 32'hFFFFFFFF};
    logic [31:0] eh [6] = '{32'hFFFFFFFF, 32'd2, 32'd5, 32'h0, 32'd1, 32'hFFFFFFF9};
    int bc, dc;
    for (int i = 0; i < 6; i++) begin
      run_op(op[i], a[i], b[i], bc, dc);
      checks++; if (bus.lo_o !== el[i]) begin errors++; $display("FAIL div%0d_lo got %h want %h", i, bus.lo_o, el[i]); end
      checks++; if (bus.hi_o !== eh[i]) begin errors++; $display("FAIL div%0d_hi got %h want %h", i, bus.hi_o, eh[i]); end
      checks++; if (bc !== 33) begin errors++; $display("FAIL div%0d_busy_cycles got %0d want 33", i, bc); end
    end
  endtask

  task automatic test_stall();
    int n = 0;
    @(negedge clk);
    bus.md_start = 1'b1; bus.md_op = 3'd1; bus.rs_val = 32'h10; bus.rt_val = 32'h20;
    @(negedge clk);
    bus.md_start = 1'b0; bus.read_req = 1'b1;
    while (bus.busy_o === 1'b1 && n < 100) begin
      checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL stall_busy_c%0d got %b want 1", n, bus.stall_o); end
      if (n == 5) begin
        bus.read_req = 1'b0; bus.md_start = 1'b1; bus.md_op = 3'd2; bus.rs_val = 32'd9; bus.rt_val = 32'd3;
        #1;
        checks++; if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL stall_on_start got %b want 1", bus.stall_o); end
      end
      if (n == 6) begin
        bus.read_req = 1'b1; bus.md_start = 1'b0;
      end
      n++;
      @(negedge clk);
    end
    checks++; if (n !== 33) begin errors++; $display("FAIL stall_busy_cycles got %0d want 33", n); end
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL stall_after_fix got %b want 0", bus.stall_o); end
    bus.read_req = 1'b0;
    checks++; if ({bus.hi_o, bus.lo_o} !== 64'h200) begin
      errors++; $display("FAIL stall_result got %h want %h", {bus.hi_o, bus.lo_o}, 64'h200);
    end
    @(negedge clk);
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL stall_no_second_op got %b want 0", bus.busy_o); end
  endtask

  task automatic test_mthi_flush();
    int n = 0;
    write_hilo(3'd4, 32'h1234, 1'b0);
    checks++; if (bus.hi_o !== 32'h1234) begin errors++; $display("FAIL mthi got %h want 00001234", bus.hi_o); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL mthi_busy got %b want 0", bus.busy_o); end
    write_hilo(3'd5, 32'h5678, 1'b0);
    checks++; if (bus.lo_o !== 32'h5678) begin errors++; $display("FAIL mtlo got %h want 00005678", bus.lo_o); end
    write_hilo(3'd5, 32'hAAAA, 1'b1);
    checks++; if (bus.lo_o !== 32'h5678) begin errors++; $display("FAIL mtlo_flushed got %h want 00005678", bus.lo_o); end
    // Flush in RUN cycle 10.
    @(negedge clk);
    bus.md_start = 1'b1; bus.md_op = 3'd3; bus.rs_val = 32'd100; bus.rt_val = 32'd7;
    @(negedge clk);
    bus.md_start = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL flush_run_busy got %b want 0", bus.busy_o); end
    checks++; if (bus.hi_o !== 32'h1234) begin errors++; $display("FAIL flush_run_hi got %h want 00001234", bus.hi_o); end
    checks++; if (bus.lo_o !== 32'h5678) begin errors++; $display("FAIL flush_run_lo got %h want 00005678", bus.lo_o); end
    // Flush in FIX suppresses done and the write.
    @(negedge clk);
    bus.md_start = 1'b1; bus.md_op = 3'd3; bus.rs_val = 32'd100; bus.rt_val = 32'd7;
    @(negedge clk);
    bus.md_start = 1'b0;
    while (bus.done_o !== 1'b1 && n < 100) begin n++; @(negedge clk); end
    checks++; if (bus.done_o !== 1'b1) begin errors++; $display("FAIL fix_reached got %b want 1", bus.done_o); end
    bus.flush = 1'b1;
    #1;
    checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL flush_fix_done got %b want 0", bus.done_o); end
    @(negedge clk);
    bus.flush = 1'b0;
    checks++; if ({bus.hi_o, bus.lo_o} !== {32'h1234, 32'h5678}) begin
      errors++; $display("FAIL flush_fix_hilo got %h want %h", {bus.hi_o, bus.lo_o}, {32'h1234, 32'h5678});
    end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL flush_fix_busy got %b want 0", bus.busy_o); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.md_start = 1'b1; bus.md_op = 3'd0; bus.rs_val = 32'd3; bus.rt_val = 32'd4;
    @(negedge clk);
    bus.md_start = 1'b0; bus.read_req = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.hi_o, bus.lo_o} !== 64'h0) begin
      errors++; $display("FAIL midreset_hilo got %h want 0", {bus.hi_o, bus.lo_o});
    end
    checks++; if ({bus.busy_o, bus.done_o, bus.stall_o} !== 3'b000) begin
      errors++; $display("FAIL midreset_flags got %b want 000", {bus.busy_o, bus.done_o, bus.stall_o});
    end
    @(negedge clk);
    rst_n = 1'b1; bus.read_req = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL midreset_abandon_busy got %b want 0", bus.busy_o); end
    checks++; if (bus.lo_o !== 32'h0) begin errors++; $display("FAIL midreset_abandon_lo got %h want 0", bus.lo_o); end
  endtask

  task automatic test_madd();
`ifdef MDU_MADD_EN
    int bc, dc;
    write_hilo(3'd5, 32'hFFFFFFFF, 1'b0);
    write_hilo(3'd4, 32'h0, 1'b0);
    run_op(3'd7, 32'd1, 32'd1, bc, dc);
    checks++; if (bc !== 33) begin errors++; $display("FAIL maddu_busy_cycles got %0d want 33", bc); end
    checks++; if ({bus.hi_o, bus.lo_o} !== 64'h1_00000000) begin
      errors++; $display("FAIL maddu_hilo got %h want %h", {bus.hi_o, bus.lo_o}, 64'h1_00000000);
    end
    run_op(3'd6, 32'hFFFFFFFF, 32'd1, bc, dc);
    checks++; if ({bus.hi_o, bus.lo_o} !== 64'h0_FFFFFFFF) begin
      errors++; $display("FAIL madd_hilo got %h want %h", {bus.hi_o, bus.lo_o}, 64'h0_FFFFFFFF);
    end
`else
    write_hilo(3'd5, 32'hAB, 1'b0);
    write_hilo(3'd4, 32'h0, 1'b0);
    @(negedge clk);
    bus.md_start = 1'b1; bus.md_op = 3'd7; bus.rs_val = 32'd1; bus.rt_val = 32'd1;
    #1;
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL maddu_off_stall got %b want 0", bus.stall_o); end
    @(negedge clk);
    bus.md_start = 1'b0;
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL maddu_off_busy got %b want 0", bus.busy_o); end
    repeat (2) @(negedge clk);
    checks++; if ({bus.hi_o, bus.lo_o} !== 64'hAB) begin
      errors++; $display("FAIL maddu_off_hilo got %h want %h", {bus.hi_o, bus.lo_o}, 64'hAB);
    end
`endif
  endtask

  initial begin
    bus.md_start = 1'b0; bus.md_op = 3'd0; bus.rs_val = '0; bus.rt_val = '0;
    bus.read_req = 1'b0; bus.flush = 1'b0;
    test_reset();
    test_multu_max();
    test_mult();
    test_div();
    test_stall();
    test_mthi_flush();
    test_reset_mid();
    test_madd();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
